dmem_line_server: RTL and testbench
===================================

// Module: dmem_line_server
// PURPOSE
//  Backing data memory that serves the dcache's miss traffic at the memory end of its refill/write-back interface.
//  Accepts one line request at a time: ALLOCATE = line read, WRITE_BACK = line write.
//  Read lines are returned as LINE_WORDS consecutive beats; write-back lines are absorbed as LINE_WORDS beats.
//  Models a fixed access LATENCY so cache miss paths see realistic timing.
// PARAMETERS
//  MEM_WORDS   16384  storage depth in 32-bit words; power of two
//  LINE_WORDS  4      words per line; power of two, >=2
//  LATENCY     4      access delay in cycles; >=1
// PORTS
//  clk          in   1   clock; all state on posedge
//  rst          in   1   asynchronous, active-low reset
//  req_valid    in   1   line request present
//  req_ready    out  1   server idle; handshake = req_valid & req_ready
//  req_write    in   1   1 = write-back line, 0 = allocate (read) line
//  req_addr     in   32  byte address of line; offset bits ignored
//  wdata_valid  in   1   write beat present
//  wdata_ready  out  1   server accepting write beats
//  wdata        in   32  write beat data
//  rdata_valid  out  1   read beat valid; no backpressure, cache must take it
//  rdata        out  32  read beat data
//  rdata_last   out  1   marks final beat of a read line
//  wack         out  1   one-cycle pulse: write-back line committed
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, beat and latency counters=0; all outputs 0 including req_ready; memory contents kept.
//  Reset acts immediately, mid-operation too; the transfer is aborted.
//  Beats already written stay written; no wack is issued for an aborted transfer.
//  Line base word index = req_addr[log2(MEM_WORDS)+1:2] with the low log2(LINE_WORDS) bits forced to 0.
//  Upper address bits are dropped, so addresses wrap modulo MEM_WORDS*4 bytes.
//  Beat k accesses word base+k; k counts 0..LINE_WORDS-1 and never crosses the line.
//  States:
//   IDLE: req_ready=1 (only while rst=1); wdata and req fields are ignored.
//    On handshake, latch write flag and base; go to WDATA if req_write, else RWAIT.
//   RWAIT: count LATENCY-1 cycles, then go to RDATA.
//   RDATA: one beat per cycle, registered from memory.
//    If the handshake is in cycle 0, rdata_valid is high in cycles LATENCY..LATENCY+LINE_WORDS-1.
//    rdata_last is high on the final beat. Then return to IDLE; req_ready is high the next cycle.
//   WDATA: wdata_ready=1. Each cycle with wdata_valid=1 writes wdata to base+k and increments k.
//    Stalls (wdata_valid=0) are allowed without limit. After the beat with k=LINE_WORDS-1, go to WWAIT.
//   WWAIT: wdata_ready=0. wack pulses exactly LATENCY cycles after the last-beat cycle.
//    Go to IDLE; req_ready is high the cycle after wack.
//  rdata holds its last value when rdata_valid=0. rdata_valid, rdata_last and wack are 0 outside their states.
//  req_valid while busy: no handshake, request held by initiator, no side effect.
//  Only one line is outstanding at a time; no pipelining of requests.
//  A read that follows a write-back to the same line returns the new data.
// TESTING  (LINE_WORDS=4, LATENCY=4, MEM_WORDS=16384, mem[i]=i preloaded)
//  Reset: rst=0 with req_valid=1 -> req_ready=0, rdata_valid=0, wack=0.
//   Release -> req_ready=1 next cycle, no request taken during reset.
//  Read 0x40, handshake cycle 0 -> rdata_valid cycles 4..7 with rdata 0x10, 0x11, 0x12, 0x13.
//   rdata_last only in cycle 7; req_ready=1 in cycle 8.
//  Write 0x80 with beats AA000000..AA000003, 2 idle cycles between beats 1 and 2 -> wdata_ready drops after beat 3.
//   wack 4 cycles after beat 3; a read of 0x80 then returns AA000000..AA000003.
//  Unaligned read 0x8C -> same beats as read 0x80, beat order 0x20..0x23 (or written data if preceded by the write test).
//  Wrap: read 0x10040 -> beats identical to read 0x40.
//  Reset mid-write after 2 beats to 0xC0 -> outputs 0 at once.
//   mem[0x30]=AA, mem[0x31]=BB written; mem[0x32]=0x32, mem[0x33]=0x33 unchanged; no wack; req_ready=1 after release.

Source files
------------

// File: rtl/dmem_line_server_if.sv
// Line-request bus between the dcache miss logic (master) and the backing
// data memory (slave): request handshake, write-beat channel, read-beat channel.
interface dmem_line_server_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        wack;

  modport master (
    output req_valid, req_write, req_addr, wdata_valid, wdata,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wack
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata_valid, wdata,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wack
  );
endinterface

// File: rtl/dmem_line_server.sv
// Backing data memory serving one cache line at a time: allocate reads return
// LINE_WORDS beats after LATENCY cycles, write-backs absorb LINE_WORDS beats.
module dmem_line_server #(
  parameter int MEM_WORDS  = 16384,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_line_server_if.slave  bus
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [OFF_W-1:0] BEAT_END = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WWAIT} state_t;

  state_t            state_q;
  logic [LINE_W-1:0] lineIdx_q;
  logic [OFF_W-1:0]  beat_q;
  logic [LAT_W-1:0]  latCnt_q;
  logic              reqReady_q;
  logic              wdataReady_q;
  logic              rdataValid_q;
  logic              rdataLast_q;
  logic [31:0]       rdata_q;
  logic              wack_q;

  logic [31:0]       mem_q [MEM_WORDS];

  logic [LINE_W-1:0] reqLine;
  logic [OFF_W-1:0]  nextBeat;
  logic              handshake;
  logic              wrBeat;
  logic              unusedAddrBits;

  // Offset and high address bits are dropped so requests wrap and align to a line.
  assign reqLine        = bus.req_addr[IDX_W+1:OFF_W+2];
  assign unusedAddrBits = ^bus.req_addr;
  assign nextBeat       = beat_q + 1'b1;
  assign handshake      = bus.req_valid & reqReady_q;
  assign wrBeat         = bus.wdata_valid & wdataReady_q;

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wrBeat) begin
      mem_q[{lineIdx_q, beat_q}] <= bus.wdata;
    end
  end

  // The cycle carrying wack is spent in IDLE with req_ready still low, so
  // req_ready rises only on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lineIdx_q    <= '0;
      beat_q       <= '0;
      latCnt_q     <= '0;
      reqReady_q   <= 1'b0;
      wdataReady_q <= 1'b0;
      rdataValid_q <= 1'b0;
      rdataLast_q  <= 1'b0;
      rdata_q      <= '0;
      wack_q       <= 1'b0;
    end else begin
      wack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            reqReady_q <= 1'b0;
            lineIdx_q  <= reqLine;
            beat_q     <= '0;
            latCnt_q   <= '0;
            if (bus.req_write) begin
              state_q      <= WDATA;
              wdataReady_q <= 1'b1;
            end else if (LATENCY == 1) begin
              state_q      <= RDATA;
              rdataValid_q <= 1'b1;
              rdataLast_q  <= 1'b0;
              rdata_q      <= mem_q[{reqLine, {OFF_W{1'b0}}}];
            end else begin
              state_q <= RWAIT;
            end
          end else begin
            reqReady_q <= 1'b1;
          end
        end
        RWAIT: begin
          if (latCnt_q == LAT_END) begin
            state_q      <= RDATA;
            rdataValid_q <= 1'b1;
            rdataLast_q  <= 1'b0;
            rdata_q      <= mem_q[{lineIdx_q, beat_q}];
          end else begin
            latCnt_q <= latCnt_q + 1'b1;
          end
        end
        RDATA: begin
          if (beat_q == BEAT_END) begin
            state_q      <= IDLE;
            rdataValid_q <= 1'b0;
            rdataLast_q  <= 1'b0;
            reqReady_q   <= 1'b1;
          end else begin
            beat_q      <= nextBeat;
            rdataLast_q <= (nextBeat == BEAT_END);
            rdata_q     <= mem_q[{lineIdx_q, nextBeat}];
          end
        end
        WDATA: begin
          if (wrBeat) begin
            beat_q <= nextBeat;
            if (beat_q == BEAT_END) begin
              wdataReady_q <= 1'b0;
              latCnt_q     <= '0;
              if (LATENCY == 1) begin
                state_q <= IDLE;
                wack_q  <= 1'b1;
              end else begin
                state_q <= WWAIT;
              end
            end
          end
        end
        WWAIT: begin
          if (latCnt_q == LAT_END) begin
            state_q <= IDLE;
            wack_q  <= 1'b1;
          end else begin
            latCnt_q <= latCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = reqReady_q;
  assign bus.wdata_ready = wdataReady_q;
  assign bus.rdata_valid = rdataValid_q;
  assign bus.rdata_last  = rdataLast_q;
  assign bus.rdata       = rdata_q;
  assign bus.wack        = wack_q;

endmodule

// File: tb/tb_dmem_line_server.sv
// Randomized line traffic against a word-array model of the backing memory,
// plus directed reset, alignment, wrap and mid-write reset scenarios.
module tb_dmem_line_server;

  localparam int MEM_WORDS  = 16384;
  localparam int LINE_WORDS = 4;
  localparam int LATENCY    = 4;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  logic [31:0] refMem    [MEM_WORDS];
  logic [31:0] beatData  [LINE_WORDS];
  int          beatGap   [LINE_WORDS];

  dmem_line_server_if bus();

  dmem_line_server #(
    .MEM_WORDS (MEM_WORDS),
    .LINE_WORDS(LINE_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guards against a design that never completes a transfer.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr);
    bus.req_valid = valid;
    bus.req_write = write;
    bus.req_addr  = addr;
  endtask

  // Word index of the first word of the line holding a byte address.
  function automatic int lineBase(input logic [31:0] addr);
    int w;
    w = int'((addr >> 2) % MEM_WORDS);
    return w - (w % LINE_WORDS);
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input string tag);
    int waitCnt;
    waitCnt = 0;
    while (bus.req_ready !== 1'b1 && waitCnt < 100) begin
      nextCycle();
      waitCnt++;
    end
    checkOutput({tag, " req_ready"}, bus.req_ready, 32'd1);
  endtask

  // Issue a line read; a conflicting request is held during the busy window
  // and must be ignored.
  task automatic readLine(input logic [31:0] addr, input string tag);
    int base;
    base = lineBase(addr);
    applyStimulus(1'b1, 1'b0, addr);
    waitReady(tag);
    nextCycle();
    applyStimulus(1'b1, 1'b1, addr ^ 32'h0000_0040);
    for (int c = 1; c < LATENCY + LINE_WORDS; c++) begin
      if (c >= LATENCY) begin
        checkOutput($sformatf("%s beat%0d valid", tag, c - LATENCY), bus.rdata_valid, 32'd1);
        checkOutput($sformatf("%s beat%0d rdata", tag, c - LATENCY), bus.rdata, refMem[base + c - LATENCY]);
        checkOutput($sformatf("%s beat%0d last", tag, c - LATENCY), bus.rdata_last,
                    {31'd0, (c == LATENCY + LINE_WORDS - 1)});
      end else begin
        checkOutput($sformatf("%s cycle%0d valid", tag, c), bus.rdata_valid, 32'd0);
      end
      checkOutput($sformatf("%s cycle%0d req_ready", tag, c), bus.req_ready, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput({tag, " end req_ready"}, bus.req_ready, 32'd1);
    checkOutput({tag, " end valid"}, bus.rdata_valid, 32'd0);
    checkOutput({tag, " end last"}, bus.rdata_last, 32'd0);
    checkOutput({tag, " rdata hold"}, bus.rdata, refMem[base + LINE_WORDS - 1]);
  endtask

  // Write back beatData with beatGap idle cycles before each beat.
  task automatic writeLine(input logic [31:0] addr, input string tag);
    int base;
    base = lineBase(addr);
    applyStimulus(1'b1, 1'b1, addr);
    waitReady(tag);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    for (int b = 0; b < LINE_WORDS; b++) begin
      for (int g = 0; g < beatGap[b]; g++) begin
        checkOutput($sformatf("%s stall%0d wdata_ready", tag, b), bus.wdata_ready, 32'd1);
        nextCycle();
      end
      checkOutput($sformatf("%s beat%0d wdata_ready", tag, b), bus.wdata_ready, 32'd1);
      checkOutput($sformatf("%s beat%0d wack", tag, b), bus.wack, 32'd0);
      bus.wdata_valid = 1'b1;
      bus.wdata       = beatData[b];
      refMem[base + b] = beatData[b];
      nextCycle();
      bus.wdata_valid = 1'b0;
      bus.wdata       = $urandom;
    end
    checkOutput({tag, " wdata_ready drop"}, bus.wdata_ready, 32'd0);
    for (int d = 1; d < LATENCY; d++) begin
      checkOutput($sformatf("%s wait%0d wack", tag, d), bus.wack, 32'd0);
      nextCycle();
    end
    checkOutput({tag, " wack pulse"}, bus.wack, 32'd1);
    checkOutput({tag, " req_ready at wack"}, bus.req_ready, 32'd0);
    nextCycle();
    checkOutput({tag, " wack end"}, bus.wack, 32'd0);
    checkOutput({tag, " req_ready after wack"}, bus.req_ready, 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    int          idle;
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < MEM_WORDS; i++) refMem[i] = 32'(i);
    for (int b = 0; b < LINE_WORDS; b++) beatGap[b] = 0;

    // Reset with a request pending: nothing may be taken.
    rst             = 1'b0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'h40);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_ready", bus.req_ready, 32'd0);
    checkOutput("reset rdata_valid", bus.rdata_valid, 32'd0);
    checkOutput("reset wack", bus.wack, 32'd0);
    checkOutput("reset wdata_ready", bus.wdata_ready, 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    checkOutput("release req_ready", bus.req_ready, 32'd0);
    nextCycle();
    checkOutput("post-release req_ready", bus.req_ready, 32'd1);
    nextCycle();
    checkOutput("post-release idle valid", bus.rdata_valid, 32'd0);
    checkOutput("post-release idle ready", bus.req_ready, 32'd1);

    // Preload lines 0..63 with mem[i] = i through the write path.
    for (int l = 0; l < 64; l++) begin
      for (int b = 0; b < LINE_WORDS; b++) beatData[b] = 32'(l * LINE_WORDS + b);
      writeLine(32'(l * LINE_WORDS * 4), $sformatf("preload%0d", l));
    end

    readLine(32'h0000_0040, "read40");

    for (int b = 0; b < LINE_WORDS; b++) begin
      beatData[b] = 32'hAA00_0000 + 32'(b);
      beatGap[b]  = (b == 2) ? 2 : 0;
    end
    writeLine(32'h0000_0080, "write80");
    for (int b = 0; b < LINE_WORDS; b++) beatGap[b] = 0;
    readLine(32'h0000_0080, "read80");
    readLine(32'h0000_008C, "read8C");
    readLine(32'h0001_0040, "wrap10040");

    // Reset after two beats of a write-back: those beats stay, no wack.
    applyStimulus(1'b1, 1'b1, 32'h0000_00C0);
    waitReady("abortC0");
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    bus.wdata_valid = 1'b1;
    bus.wdata       = 32'hAA;
    refMem[32'h30]  = 32'hAA;
    nextCycle();
    bus.wdata      = 32'hBB;
    refMem[32'h31] = 32'hBB;
    nextCycle();
    bus.wdata_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort wdata_ready", bus.wdata_ready, 32'd0);
    checkOutput("abort req_ready", bus.req_ready, 32'd0);
    checkOutput("abort rdata_valid", bus.rdata_valid, 32'd0);
    checkOutput("abort wack", bus.wack, 32'd0);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("abort release req_ready", bus.req_ready, 32'd1);
    for (int d = 0; d < LATENCY + 2; d++) begin
      checkOutput($sformatf("abort no wack %0d", d), bus.wack, 32'd0);
      nextCycle();
    end
    readLine(32'h0000_00C0, "readC0");

    // Random traffic confined to the preloaded lines, with junk high bits.
    for (int t = 0; t < 150; t++) begin
      addr = $urandom & 32'hFFFF_03FF;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        bus.wdata_valid = 1'b1;
        bus.wdata       = $urandom;
        nextCycle();
        checkOutput("idle wdata_ready", bus.wdata_ready, 32'd0);
      end
      bus.wdata_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < LINE_WORDS; b++) begin
          beatData[b] = $urandom;
          beatGap[b]  = $urandom_range(0, 2);
        end
        writeLine(addr, $sformatf("rndW%0d", t));
      end else begin
        readLine(addr, $sformatf("rndR%0d", t));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
